div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 128 ++++++++++++
 tb/tb_div_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: 32 iterations on operand
// magnitudes, then a one-cycle DONE with {remainder, quotient} and a ready pulse.
module div_unit #(
  parameter logic [4:0] DIV_CONTROL  = 5'b11010,
  parameter logic [4:0] DIVU_CONTROL = 5'b11011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  alucontrol,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        annul,
  output logic        div_stall,
  output logic        div_ready,
  output logic [63:0] div_result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quot;
  logic [31:0] r_div;
  logic [31:0] r_a;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_ready;
  logic [63:0] r_result;

  logic        w_start;
  logic        w_signed;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_rem_nx;
  logic [31:0] w_quot_nx;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;
  logic [63:0] w_final;

  assign w_start  = (alucontrol == DIV_CONTROL) || (alucontrol == DIVU_CONTROL);
  assign w_signed = (alucontrol == DIV_CONTROL);
  assign w_a_mag  = (w_signed && a[31]) ? (32'd0 - a) : a;
  assign w_b_mag  = (w_signed && b[31]) ? (32'd0 - b) : b;

  // Partial remainder stays below the divisor, so bit 32 of the difference is
  // a reliable borrow flag whenever the divisor is non-zero.
  assign w_shift   = {r_rem, r_quot[31]};
  assign w_diff    = w_shift - {1'b0, r_div};
  assign w_ge      = ~w_diff[32];
  assign w_rem_nx  = w_ge ? w_diff[31:0] : w_shift[31:0];
  assign w_quot_nx = {r_quot[30:0], w_ge};

  assign w_q_fix = r_neg_q ? (32'd0 - w_quot_nx) : w_quot_nx;
  assign w_r_fix = r_neg_r ? (32'd0 - w_rem_nx) : w_rem_nx;
  assign w_final = (r_div == '0) ? {r_a, 32'hFFFF_FFFF} : {w_r_fix, w_q_fix};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quot   <= '0;
      r_div    <= '0;
      r_a      <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_ready  <= 1'b0;
      r_result <= '0;
    end else if (annul) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ready <= 1'b0;
          if (w_start) begin
            r_rem   <= '0;
            r_quot  <= w_a_mag;
            r_div   <= w_b_mag;
            r_a     <= a;
            r_neg_q <= w_signed && (a[31] ^ b[31]);
            r_neg_r <= w_signed && a[31];
            r_cnt   <= '0;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_rem  <= w_rem_nx;
          r_quot <= w_quot_nx;
          r_cnt  <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            r_result <= w_final;
            r_ready  <= 1'b1;
            r_state  <= DONE;
          end
        end
        DONE: begin
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    div_stall = 1'b0;
    if (!annul) begin
      case (r_state)
        IDLE:    div_stall = w_start;
        CALC:    div_stall = 1'b1;
        default: div_stall = 1'b0;
      endcase
    end
  end

  assign div_ready  = r_ready;
  assign div_result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized
// DIV/DIVU against an arithmetic reference model.
module tb_div_unit;

  localparam logic [4:0] C_DIV  = 5'b11010;
  localparam logic [4:0] C_DIVU = 5'b11011;
  localparam logic [4:0] C_NOP  = 5'b00000;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  alucontrol;
  logic [31:0] a;
  logic [31:0] b;
  logic        annul;
  logic        div_stall;
  logic        div_ready;
  logic [63:0] div_result;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  div_unit #(.DIV_CONTROL(C_DIV), .DIVU_CONTROL(C_DIVU)) dut (
    .clk        (clk),
    .rst        (rst),
    .alucontrol (alucontrol),
    .a          (a),
    .b          (b),
    .annul      (annul),
    .div_stall  (div_stall),
    .div_ready  (div_ready),
    .div_result (div_result)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // HI = remainder, LO = quotient; divide by zero returns {dividend, all-ones}
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] x, input logic [31:0] y);
    longint q;
    longint r;
    longint sx;
    longint sy;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (sgn) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'd0, x});
      sy = longint'({32'd0, y});
    end
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [4:0] nop_code();
    logic [4:0] c;
    do c = 5'($urandom_range(0, 31)); while (c == C_DIV || c == C_DIVU);
    return c;
  endfunction

  // Called just after a negedge; that cycle is T. Returns just after the T+34 negedge.
  task automatic run_div(input logic [4:0] op, input logic [31:0] da, input logic [31:0] db,
                         input logic [63:0] exp, input bit hold_done);
    int bad;
    alucontrol = op; a = da; b = db; annul = 1'b0;
    #1 check("stall_T", 64'(div_stall), 64'd1);
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      alucontrol = nop_code(); a = $urandom; b = $urandom;
      #1 if (div_stall !== 1'b1 || div_ready !== 1'b0) bad++;
    end
    check("calc_window", 64'(bad), 64'd0);
    @(negedge clk);
    if (hold_done) begin alucontrol = op; a = da; b = db; end
    #1;
    check("ready_T33", 64'(div_ready), 64'd1);
    check("stall_T33", 64'(div_stall), 64'd0);
    check("result", div_result, exp);
    @(negedge clk);
    alucontrol = C_NOP;
    #1;
    check("ready_T34", 64'(div_ready), 64'd0);
    check("stall_T34", 64'(div_stall), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] last;
    logic [4:0]  op;
    logic [31:0] ra;
    logic [31:0] rb;
    int          bad;

    rst = 1'b1; annul = 1'b0; alucontrol = C_NOP; a = '0; b = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_result", div_result, 64'd0);
    check("rst_ready", 64'(div_ready), 64'd0);
    check("rst_stall", 64'(div_stall), 64'd0);

    // A start during reset must not launch a divide
    @(negedge clk);
    alucontrol = C_DIVU; a = 32'd50; b = 32'd5;
    @(negedge clk);
    alucontrol = C_NOP;
    #1 check("rst_prio_stall", 64'(div_stall), 64'd0);
    rst = 1'b0;

    run_div(C_DIVU, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E}, 1'b0);
    run_div(C_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
    run_div(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 1'b0);
    run_div(C_DIVU, 32'd5, 32'd0, {32'h0000_0005, 32'hFFFF_FFFF}, 1'b0);
    run_div(C_DIV, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1'b1);
    run_div(C_DIV, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 1'b0);
    last = {32'hFFFF_FFFB, 32'hFFFF_FFFF};
    last = {32'h0000_0001, 32'hFFFF_FFFD};

    // Result must hold between completions
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      alucontrol = nop_code(); a = $urandom; b = $urandom;
      #1 if (div_result !== last || div_ready !== 1'b0) bad++;
    end
    check("result_hold", 64'(bad), 64'd0);

    // Annul together with a start in IDLE: nothing launches
    @(negedge clk);
    alucontrol = C_DIVU; a = 32'd77; b = 32'd7; annul = 1'b1;
    #1 check("annul_start_stall", 64'(div_stall), 64'd0);
    @(negedge clk);
    alucontrol = C_NOP; annul = 1'b0;
    #1 check("annul_start_idle", 64'(div_stall), 64'd0);

    // Annul at T+10 cancels; a new divide at T+11 completes at T+44
    @(negedge clk);
    alucontrol = C_DIVU; a = 32'd1000; b = 32'd3;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      alucontrol = nop_code();
    end
    @(negedge clk);
    annul = 1'b1;
    #1;
    check("annul_stall", 64'(div_stall), 64'd0);
    check("annul_ready", 64'(div_ready), 64'd0);
    @(negedge clk);
    annul = 1'b0;
    run_div(C_DIVU, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0);
    last = {32'd0, 32'd3};

    // Reset in the middle of CALC
    @(negedge clk);
    alucontrol = C_DIV; a = 32'hDEAD_BEEF; b = 32'd13;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      alucontrol = nop_code();
    end
    @(negedge clk);
    rst = 1'b1; alucontrol = C_NOP;
    @(negedge clk);
    #1;
    check("midrst_result", div_result, 64'd0);
    check("midrst_ready", 64'(div_ready), 64'd0);
    check("midrst_stall", 64'(div_stall), 64'd0);
    rst = 1'b0;

    // Randomized back-to-back divides, first one in the first IDLE cycle after reset
    for (int n = 0; n < 24; n++) begin
      op = ($urandom_range(0, 1) == 0) ? C_DIV : C_DIVU;
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3:       rb = 32'($urandom) | 32'h8000_0000;
        default: rb = $urandom;
      endcase
      run_div(op, ra, rb, ref_div(op == C_DIV, ra, rb), n[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
